// File: rtl/dmem_pkg.sv
// Shared types and helpers for the latency-configurable data memory.
// Covers the FSM state encoding, the counter sizing constant and width helpers.
package dmem_pkg;

  localparam int LAT_MAX = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int lanes(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/dmem_latency_ctrl_if.sv
// Request/response bus between the load/store path (master) and dmem_latency_ctrl (slave).
interface dmem_latency_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  import dmem_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [lanes(WIDTH)-1:0]    req_be;
  logic [ADDR_W-1:0]          req_addr;
  logic [WIDTH-1:0]           req_wdata;
  logic                       rsp_valid;
  logic [WIDTH-1:0]           rsp_rdata;
  logic                       rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_byte_ram.sv
// DEPTH x WIDTH word RAM with per-byte-lane writes, async clear and a registered read port.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [clog2(DEPTH)-1:0]   idx,
  input  logic [lanes(WIDTH)-1:0]   wr_be,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      rd_ld,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_word
);

  localparam int LANES = lanes(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read register reloads on every accepted request, so writes and errors leave it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
      rd_word <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (rd_ld) rd_word <= rd_en ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/dmem_latency_ctrl.sv
// Data memory with valid/ready requests, byte-enable writes, fixed read latency and
// misalignment/out-of-range error reporting; one request outstanding at a time.
module dmem_latency_ctrl
  import dmem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_latency_ctrl_if.slave   bus
);

  localparam int LSB   = clog2(lanes(WIDTH));
  localparam int IDX_W = clog2(DEPTH);
  localparam int CNT_W = clog2(LAT_MAX + 1);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     accept;
  logic                     misaligned;
  logic                     out_of_range;
  logic                     err;
  logic [IDX_W-1:0]         idx;
  logic [lanes(WIDTH)-1:0]  wr_be;

  assign accept       = bus.req_valid && bus.req_ready;
  assign misaligned   = |bus.req_addr[LSB-1:0];
  assign out_of_range = (bus.req_addr >> (LSB + IDX_W)) != '0;
  assign err          = misaligned || out_of_range;
  assign idx          = bus.req_addr[LSB +: IDX_W];
  assign wr_be        = (accept && bus.req_we && !err) ? bus.req_be : '0;

  dmem_byte_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .idx     (idx),
    .wr_be   (wr_be),
    .wdata   (bus.req_wdata),
    .rd_ld   (accept),
    .rd_en   (!bus.req_we && !err),
    .rd_word (bus.rsp_rdata)
  );

  // req_ready and rsp_valid are registered so they reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            bus.rsp_err <= err;
            if (LATENCY == 1) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.req_ready <= 1'b1;
            end else begin
              state         <= WAIT;
              cnt           <= CNT_W'(LATENCY - 1);
              bus.req_ready <= 1'b0;
            end
          end else begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.req_ready <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// Directed bench for dmem_latency_ctrl at LATENCY 1, 2 and 3 sharing one request driver.
module tb_dmem_latency_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  int          sel = 2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_latency_ctrl_if #(.WIDTH(32), .ADDR_W(32)) bus1 ();
  dmem_latency_ctrl_if #(.WIDTH(32), .ADDR_W(32)) bus2 ();
  dmem_latency_ctrl_if #(.WIDTH(32), .ADDR_W(32)) bus3 ();

  assign bus1.req_valid = valid && (sel == 1);
  assign bus2.req_valid = valid && (sel == 2);
  assign bus3.req_valid = valid && (sel == 3);
  assign bus1.req_we = we;    assign bus2.req_we = we;    assign bus3.req_we = we;
  assign bus1.req_be = be;    assign bus2.req_be = be;    assign bus3.req_be = be;
  assign bus1.req_addr = addr; assign bus2.req_addr = addr; assign bus3.req_addr = addr;
  assign bus1.req_wdata = wdata; assign bus2.req_wdata = wdata; assign bus3.req_wdata = wdata;

  dmem_latency_ctrl #(.WIDTH(32), .DEPTH(256), .ADDR_W(32), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_latency_ctrl #(.WIDTH(32), .DEPTH(256), .ADDR_W(32), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  dmem_latency_ctrl #(.WIDTH(32), .DEPTH(256), .ADDR_W(32), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic        ready_s, rvld_s, rerr_s;
  logic [31:0] rdata_s;

  assign ready_s = (sel == 1) ? bus1.req_ready : (sel == 2) ? bus2.req_ready : bus3.req_ready;
  assign rvld_s  = (sel == 1) ? bus1.rsp_valid : (sel == 2) ? bus2.rsp_valid : bus3.rsp_valid;
  assign rerr_s  = (sel == 1) ? bus1.rsp_err   : (sel == 2) ? bus2.rsp_err   : bus3.rsp_err;
  assign rdata_s = (sel == 1) ? bus1.rsp_rdata : (sel == 2) ? bus2.rsp_rdata : bus3.rsp_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request, then check the pulse lands exactly lat cycles after acceptance and is one cycle wide.
  task automatic xact(input string tag, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input int lat, input logic [31:0] exp_d, input logic exp_e);
    int n;
    @(negedge clk);
    we = w; be = b; addr = a; wdata = d; valid = 1'b1;
    n = 0;
    while (!ready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'b0, ready_s}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      if (k < lat) chk({tag, "_early"}, {31'b0, rvld_s}, 32'd0);
    end
    chk({tag, "_vld"}, {31'b0, rvld_s}, 32'd1);
    chk({tag, "_data"}, rdata_s, exp_d);
    chk({tag, "_err"}, {31'b0, rerr_s}, {31'b0, exp_e});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, rvld_s}, 32'd0);
  endtask

  // Hold req_valid high across four reads and log accept/response cycles.
  task automatic burst(input string tag, input int lat, input logic [31:0] base_val);
    int ac[$];
    int rc[$];
    logic [31:0] rq[$];
    int i;
    i = 0;
    for (int c = 0; c < 4 * lat + 4; c++) begin
      @(negedge clk);
      if (rvld_s) begin
        rq.push_back(rdata_s);
        rc.push_back(c);
      end
      if (i < 4) begin
        valid = 1'b1; we = 1'b0; addr = 32'(i * 4);
        if (ready_s) begin
          ac.push_back(c);
          i++;
        end
      end else begin
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    chk({tag, "_nacc"}, 32'(ac.size()), 32'd4);
    chk({tag, "_nrsp"}, 32'(rc.size()), 32'd4);
    if (ac.size() == 4 && rc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk({tag, "_rdata"}, rq[k], base_val + 32'(k));
        chk({tag, "_lat"}, 32'(rc[k] - ac[k]), 32'(lat));
        if (k > 0) begin
          chk({tag, "_accgap"}, 32'(ac[k] - ac[k-1]), 32'(lat));
          chk({tag, "_rspgap"}, 32'(rc[k] - rc[k-1]), 32'(lat));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted mid-cycle takes effect without a clock edge.
    sel = 2;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", {31'b0, ready_s}, 32'd1);
    chk("rst_vld", {31'b0, rvld_s}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xact("rd_after_rst", 1'b0, 4'hF, 32'h10, 32'h0, 2, 32'h0, 1'b0);

    xact("wr_full", 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    xact("rd_full", 1'b0, 4'h0, 32'h20, 32'h0, 2, 32'hDEADBEEF, 1'b0);

    xact("wr_pre", 1'b1, 4'hF, 32'h40, 32'h11223344, 2, 32'h0, 1'b0);
    xact("wr_be5", 1'b1, 4'h5, 32'h40, 32'hAABBCCDD, 2, 32'h0, 1'b0);
    xact("rd_be5", 1'b0, 4'h0, 32'h40, 32'h0, 2, 32'h11BB33DD, 1'b0);
    xact("wr_be0", 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 2, 32'h0, 1'b0);
    xact("rd_be0", 1'b0, 4'h0, 32'h40, 32'h0, 2, 32'h11BB33DD, 1'b0);

    xact("wr_w0", 1'b1, 4'hF, 32'h0, 32'h5A5A0000, 2, 32'h0, 1'b0);
    xact("rd_mis", 1'b0, 4'h0, 32'h42, 32'h0, 2, 32'h0, 1'b1);
    xact("wr_oor", 1'b1, 4'hF, 32'h400, 32'h12345678, 2, 32'h0, 1'b1);
    xact("rd_w0", 1'b0, 4'h0, 32'h0, 32'h0, 2, 32'h5A5A0000, 1'b0);
    xact("rd_good", 1'b0, 4'h0, 32'h20, 32'h0, 2, 32'hDEADBEEF, 1'b0);

    sel = 1;
    for (int k = 0; k < 4; k++)
      xact("l1_pre", 1'b1, 4'hF, 32'(k * 4), 32'hA0000001 + 32'(k), 1, 32'h0, 1'b0);
    burst("l1_b2b", 1, 32'hA0000001);

    sel = 3;
    for (int k = 0; k < 4; k++)
      xact("l3_pre", 1'b1, 4'hF, 32'(k * 4), 32'hB0000010 + 32'(k), 3, 32'h0, 1'b0);
    burst("l3_b2b", 3, 32'hB0000010);

    // Reset while a read waits out its latency.
    xact("l3_wr80", 1'b1, 4'hF, 32'h80, 32'hCAFEF00D, 3, 32'h0, 1'b0);
    xact("l3_rd80", 1'b0, 4'h0, 32'h80, 32'h0, 3, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    valid = 1'b1; we = 1'b0; addr = 32'h80;
    chk("mid_ready", {31'b0, ready_s}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_novld", {31'b0, rvld_s}, 32'd0);
    end
    rst = 1'b0;
    xact("l3_rd80_clr", 1'b0, 4'h0, 32'h80, 32'h0, 3, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
